// File: rtl/vga_pixel_fetch_if.sv
// Pixel-memory read bus between vga_pixel_fetch (master) and the frame memory (slave).
interface vga_pixel_fetch_if #(
  parameter int AW = 19
);
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_RD;
  logic          MEM_WAIT;
  logic [23:0]   MEM_RDATA;
  logic          MEM_RVALID;

  modport master (
    output MEM_ADDR,
    output MEM_RD,
    input  MEM_WAIT,
    input  MEM_RDATA,
    input  MEM_RVALID
  );

  modport slave (
    input  MEM_ADDR,
    input  MEM_RD,
    output MEM_WAIT,
    output MEM_RDATA,
    output MEM_RVALID
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Prefetches one frame of {R,G,B} pixels from memory into a small FIFO and
// streams them to the VGA output on active cycles; resyncs on every VS falling edge.
module vga_pixel_fetch #(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int DEPTH = 8,
  parameter int AW    = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VGA_HS,
  input  logic              VGA_VS,
  input  logic              VGA_BLANK,
  vga_pixel_fetch_if.master mem,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              UNDERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(HDISP * VDISP - 1);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  logic          rst_meta_q, rst_sync_q, rst_n_s;
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          vs_prev_q;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   fifo_mem [DEPTH];
  logic [23:0]   rgb_q;
  logic          underflow_q;

  logic          frame_start_s, mem_rd_s, accept_s, full_s, empty_s;
  logic          pop_s, keep_s, push_s, hs_unused_s;
  logic [CW:0]   credit_sum_s;

  // Assert asynchronously, release two clocks after RST rises.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n_s     = rst_sync_q;
  assign hs_unused_s = VGA_HS;

  assign frame_start_s = vs_prev_q & ~VGA_VS;
  assign credit_sum_s  = {1'b0, count_q} + {1'b0, in_flight_q};
  assign mem_rd_s      = (state_q == RUN) && (credit_sum_s < (CW+1)'(DEPTH));
  assign accept_s      = mem_rd_s && !mem.MEM_WAIT;
  assign full_s        = (count_q == CW'(DEPTH));
  assign empty_s       = (count_q == CW'(0));
  assign pop_s         = VGA_BLANK && !empty_s;
  // Responses owed to a previous frame, or arriving before the first frame, never reach the FIFO.
  assign keep_s        = mem.MEM_RVALID && (drop_q == CW'(0)) && (state_q != WAIT_VS) && !frame_start_s;
  assign push_s        = keep_s && (!full_s || pop_s);

  // Fetch sequencing, credit accounting and FIFO pointer next-state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    in_flight_d = in_flight_q;
    drop_d      = drop_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (accept_s && !mem.MEM_RVALID) begin
      in_flight_d = in_flight_q + CW'(1);
    end else if (!accept_s && mem.MEM_RVALID && (in_flight_q != CW'(0))) begin
      in_flight_d = in_flight_q - CW'(1);
    end else begin
      in_flight_d = in_flight_q;
    end

    if (mem.MEM_RVALID && (drop_q != CW'(0))) begin
      drop_d = drop_q - CW'(1);
    end else begin
      drop_d = drop_q;
    end

    case (state_q)
      WAIT_VS: state_d = WAIT_VS;
      RUN: begin
        if (accept_s) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN:   state_d = DRAIN;
      default: state_d = WAIT_VS;
    endcase

    if (frame_start_s) begin
      state_d  = RUN;
      addr_d   = AW'(0);
      drop_d   = in_flight_d;
      wr_ptr_d = PW'(0);
      rd_ptr_d = PW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, counters and registered pixel output.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= WAIT_VS;
      addr_q      <= AW'(0);
      vs_prev_q   <= 1'b1;
      in_flight_q <= CW'(0);
      drop_q      <= CW'(0);
      wr_ptr_q    <= PW'(0);
      rd_ptr_q    <= PW'(0);
      count_q     <= CW'(0);
      rgb_q       <= 24'd0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      vs_prev_q   <= VGA_VS;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rgb_q       <= pop_s ? fifo_mem[rd_ptr_q] : 24'd0;
      underflow_q <= underflow_q | (VGA_BLANK & empty_s);
    end
  end

  // Pixel storage; a push into a full FIFO overwrites the slot being popped the same cycle.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q] <= mem.MEM_RDATA;
    end
  end

  assign mem.MEM_RD   = mem_rd_s;
  assign mem.MEM_ADDR = addr_q;
  assign VGA_R        = rgb_q[23:16];
  assign VGA_G        = rgb_q[15:8];
  assign VGA_B        = rgb_q[7:0];
  assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch on a 8x4 frame with an epoch-tagged memory model.
module tb_vga_pixel_fetch;
  localparam int HD = 8;
  localparam int VD = 4;
  localparam int DP = 8;
  localparam int AW = 5;
  localparam int NPIX = HD * VD;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic VGA_HS = 1'b1;
  logic VGA_VS = 1'b1;
  logic VGA_BLANK = 1'b0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic UNDERFLOW;
  logic blank_prev = 1'b0;

  vga_pixel_fetch_if #(.AW(AW)) mem_if ();

  vga_pixel_fetch #(.HDISP(HD), .VDISP(VD), .DEPTH(DP), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
    .mem(mem_if), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) blank_prev <= VGA_BLANK;

  typedef struct { int due; logic [23:0] data; } rsp_t;
  typedef struct { logic lenient; logic [23:0] val; } exp_t;

  int checks = 0;
  int errors = 0;
  int starved = 0;
  rsp_t pend_q[$];
  exp_t exp_q[$];
  logic [23:0] len_q[$];
  logic [23:0] seq_q[$];
  int cyc = 0, lat = 2, epoch = 0, acc_cnt = 0;
  logic rand_wait = 1'b0, chk_stall = 1'b0, stall_prev = 1'b0;
  logic inject = 1'b0;
  logic [23:0] inj_data = 24'h000000;
  logic [AW-1:0] addr_prev = '0;

  function automatic logic [23:0] pix(input int ep, input int a);
    return {8'(8'h80 + ep), 16'(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: memory model, stall checks, then VGA timing inputs.
  task automatic step(input logic blank, input logic vs_low, input logic lenient, input logic [23:0] val);
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (chk_stall && stall_prev && RST) begin
      check("stall_rd_hold", 32'(mem_if.MEM_RD), 32'd1);
      check("stall_addr_hold", 32'(mem_if.MEM_ADDR), 32'(addr_prev));
    end
    if (RST) check("inflight_max", 32'(pend_q.size() <= DP), 32'd1);
    mem_if.MEM_RVALID = 1'b0;
    mem_if.MEM_RDATA  = 24'h000000;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_if.MEM_RVALID = 1'b1;
      mem_if.MEM_RDATA  = pend_q[0].data;
      void'(pend_q.pop_front());
    end else if (inject) begin
      mem_if.MEM_RVALID = 1'b1;
      mem_if.MEM_RDATA  = inj_data;
    end
    inject = 1'b0;
    if (vs_low) mem_if.MEM_WAIT = 1'b1;
    else mem_if.MEM_WAIT = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    if (mem_if.MEM_RD && !mem_if.MEM_WAIT) begin
      pend_q.push_back('{cyc + lat, pix(epoch, int'(mem_if.MEM_ADDR))});
      acc_cnt++;
    end
    stall_prev = mem_if.MEM_RD && mem_if.MEM_WAIT && !vs_low;
    addr_prev  = mem_if.MEM_ADDR;
    VGA_VS    = ~vs_low;
    VGA_BLANK = blank;
    if (vs_low) epoch++;
    if (blank) begin
      e.lenient = lenient;
      e.val = val;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h000000);
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b1, 1'b0, 24'h000000);
  endtask

  task automatic build_seq(input int n);
    seq_q.delete();
    for (int i = 0; i < n; i++) seq_q.push_back(pix(epoch, i));
  endtask

  task automatic line_exact();
    logic [23:0] v;
    for (int i = 0; i < HD; i++) begin
      v = seq_q.pop_front();
      step(1'b1, 1'b0, 1'b0, v);
    end
  endtask

  // Consumes one expectation per displayed cycle; blank cycles must show black.
  task automatic monitor();
    exp_t e;
    logic [23:0] rgb;
    forever begin
      @(negedge CLK);
      rgb = {VGA_R, VGA_G, VGA_B};
      if (blank_prev) begin
        check("exp_q_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (!e.lenient) begin
            check("pixel", 32'(rgb), 32'(e.val));
          end else if (rgb != 24'h000000) begin
            check("len_q_avail", 32'(len_q.size() != 0), 32'd1);
            if (len_q.size() != 0) check("pixel_in_order", 32'(rgb), 32'(len_q.pop_front()));
          end else begin
            starved++;
          end
        end
      end else begin
        check("blank_black", 32'(rgb), 32'd0);
      end
    end
  endtask

  task automatic stimulus();
    int tries;
    mem_if.MEM_WAIT = 1'b0;
    mem_if.MEM_RVALID = 1'b0;
    mem_if.MEM_RDATA = 24'h000000;
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_mem_rd", 32'(mem_if.MEM_RD), 32'd0);
    check("rst_mem_addr", 32'(mem_if.MEM_ADDR), 32'd0);
    check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    check("rst_underflow", 32'(UNDERFLOW), 32'd0);
    RST = 1'b1;
    idle(6);
    check("wait_vs_no_rd", 32'(mem_if.MEM_RD), 32'd0);

    // Frame 1: latency 2, no stalls, whole frame in order.
    acc_cnt = 0;
    vs_pulse();
    idle(30);
    check("prefetch_credit_cnt", 32'(acc_cnt), 32'(DP));
    check("prefetch_full_no_rd", 32'(mem_if.MEM_RD), 32'd0);
    build_seq(NPIX);
    for (int l = 0; l < VD; l++) begin
      line_exact();
      idle(30);
    end
    check("frame_req_count", 32'(acc_cnt), 32'(NPIX));
    check("drain_no_rd", 32'(mem_if.MEM_RD), 32'd0);
    check("f1_underflow", 32'(UNDERFLOW), 32'd0);

    // Frame 2: random stalls, push into full FIFO with and without a pop.
    rand_wait = 1'b1;
    chk_stall = 1'b1;
    vs_pulse();
    idle(40);
    check("f2_model_idle", 32'(pend_q.size()), 32'd0);
    check("f2_full_no_rd", 32'(mem_if.MEM_RD), 32'd0);
    inj_data = 24'hDEAD01;
    inject = 1'b1;
    idle(1);
    build_seq(NPIX);
    seq_q.insert(DP, 24'hBEEF02);
    inj_data = 24'hBEEF02;
    inject = 1'b1;
    for (int l = 0; l < VD; l++) begin
      line_exact();
      idle(30);
    end
    check("f2_underflow", 32'(UNDERFLOW), 32'd0);
    rand_wait = 1'b0;
    chk_stall = 1'b0;
    mem_if.MEM_WAIT = 1'b0;

    // Frame 3: resync with exactly five requests outstanding.
    lat = 10;
    vs_pulse();
    tries = 0;
    while (pend_q.size() < 5 && tries < 20) begin
      idle(1);
      tries++;
    end
    check("inflight_before_resync", 32'(pend_q.size()), 32'd5);
    vs_pulse();
    idle(60);
    build_seq(HD);
    line_exact();
    idle(20);
    check("f3_underflow", 32'(UNDERFLOW), 32'd0);

    // Frame 4: latency 20 starves the second line.
    lat = 20;
    vs_pulse();
    idle(60);
    build_seq(HD);
    line_exact();
    idle(4);
    check("f4_no_underflow_line0", 32'(UNDERFLOW), 32'd0);
    for (int i = HD; i < NPIX; i++) len_q.push_back(pix(epoch, i));
    for (int i = 0; i < HD; i++) step(1'b1, 1'b0, 1'b1, 24'h000000);
    idle(4);
    check("f4_underflow_sticky", 32'(UNDERFLOW), 32'd1);
    check("f4_starved_seen", 32'(starved > 0), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 24'h000000);

    // Asynchronous reset pulse mid-line.
    #2 RST = 1'b0;
    #1;
    check("mid_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    check("mid_rst_rd", 32'(mem_if.MEM_RD), 32'd0);
    check("mid_rst_addr", 32'(mem_if.MEM_ADDR), 32'd0);
    check("mid_rst_underflow", 32'(UNDERFLOW), 32'd0);
    pend_q.delete();
    stall_prev = 1'b0;
    idle(1);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("post_rst_no_rd", 32'(mem_if.MEM_RD), 32'd0);
    end

    // Frame 5: normal operation after reset.
    lat = 2;
    vs_pulse();
    idle(30);
    build_seq(HD);
    line_exact();
    idle(5);
    check("f5_underflow", 32'(UNDERFLOW), 32'd0);
    tries = 0;
    while (exp_q.size() != 0 && tries < 10) begin
      idle(1);
      tries++;
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
